// File: rtl/sobel_gcd_mode_sched_if.sv
// Scheduler <-> SPI receiver / GCD core / Sobel core signal bundle.
// The master modport is the scheduler; the slave modport is its surroundings.
interface sobel_gcd_mode_sched_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  rx_valid_i;
  logic [DATA_WIDTH-1:0] rx_data_i;
  logic                  gcd_en_i;
  logic                  sobel_allowed_i;
  logic                  sobel_en_i;
  logic [DATA_WIDTH-1:0] gcd_a_o;
  logic [DATA_WIDTH-1:0] gcd_b_o;
  logic                  gcd_start_o;
  logic                  gcd_done_i;
  logic [DATA_WIDTH-1:0] gcd_result_i;
  logic [DATA_WIDTH-2:0] sobel_pixel_o;
  logic                  sobel_pixel_valid_o;
  logic                  sobel_start_o;
  logic                  sobel_done_i;
  logic [DATA_WIDTH-2:0] sobel_result_i;
  logic [DATA_WIDTH-1:0] tx_data_o;
  logic                  tx_load_o;
  logic                  done_o;
  logic                  busy_o;
  logic                  error_o;

  modport master (
    input  rx_valid_i, rx_data_i, gcd_en_i, sobel_allowed_i, sobel_en_i,
    input  gcd_done_i, gcd_result_i, sobel_done_i, sobel_result_i,
    output gcd_a_o, gcd_b_o, gcd_start_o, sobel_pixel_o, sobel_pixel_valid_o, sobel_start_o,
    output tx_data_o, tx_load_o, done_o, busy_o, error_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, gcd_en_i, sobel_allowed_i, sobel_en_i,
    output gcd_done_i, gcd_result_i, sobel_done_i, sobel_result_i,
    input  gcd_a_o, gcd_b_o, gcd_start_o, sobel_pixel_o, sobel_pixel_valid_o, sobel_start_o,
    input  tx_data_o, tx_load_o, done_o, busy_o, error_o
  );
endinterface

// File: rtl/sobel_gcd_mode_sched.sv
// Mode scheduler: routes SPI words to the GCD operands or the Sobel pixel stream,
// starts the selected core on its enable-pin rising edge and loads results for SPI TX.
module sobel_gcd_mode_sched #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SOBEL_WINDOW   = 9,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                    clk_i,
  input logic                    nreset_i,
  sobel_gcd_mode_sched_if.master bus
);

  localparam int unsigned PixW     = DATA_WIDTH - 1;
  localparam int unsigned PixCntW  = $clog2(SOBEL_WINDOW + 1);
  localparam int unsigned ToW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGcdA    = 3'd1;
  localparam logic [2:0] StGcdArm  = 3'd2;
  localparam logic [2:0] StGcdRun  = 3'd3;
  localparam logic [2:0] StGcdDone = 3'd4;
  localparam logic [2:0] StSobFill = 3'd5;
  localparam logic [2:0] StSobArm  = 3'd6;
  localparam logic [2:0] StSobRun  = 3'd7;

  logic [2:0]            state_q, state_d;
  logic                  gcd_en_q, sobel_en_q;
  logic [DATA_WIDTH-1:0] gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic                  gcd_start_q, gcd_start_d;
  logic [PixW-1:0]       pix_q, pix_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  sobel_start_q, sobel_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_load_q, tx_load_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [PixCntW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;

  logic gcd_rise, gcd_fall, sob_rise, rx, is_pix, timeout, in_sob, push;

  always_comb begin
    gcd_rise = bus.gcd_en_i & ~gcd_en_q;
    gcd_fall = ~bus.gcd_en_i & gcd_en_q;
    sob_rise = bus.sobel_en_i & ~sobel_en_q;
    rx       = bus.rx_valid_i;
    is_pix   = bus.rx_data_i[DATA_WIDTH-1];
    timeout  = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
    in_sob   = (state_q == StSobFill) || (state_q == StSobArm) || (state_q == StSobRun);

    state_d       = state_q;
    gcd_a_d       = gcd_a_q;
    gcd_b_d       = gcd_b_q;
    gcd_start_d   = 1'b0;
    sobel_start_d = 1'b0;
    tx_data_d     = tx_data_q;
    tx_load_d     = 1'b0;
    done_d        = done_q;
    error_d       = error_q;
    pix_cnt_d     = pix_cnt_q;
    to_cnt_d      = to_cnt_q + ToW'(1);
    push          = 1'b0;

    // Dropping Sobel mode overrides everything else in that cycle.
    if (in_sob && !bus.sobel_allowed_i) begin
      state_d   = StIdle;
      pix_cnt_d = '0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx) begin
            if (!bus.sobel_allowed_i && !is_pix) begin
              gcd_a_d = bus.rx_data_i;
              error_d = 1'b0;
              state_d = StGcdA;
            end else if (bus.sobel_allowed_i && is_pix) begin
              push      = 1'b1;
              pix_cnt_d = PixCntW'(1);
              error_d   = 1'b0;
              state_d   = (SOBEL_WINDOW <= 1) ? StSobArm : StSobFill;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        StGcdA: begin
          if (rx) begin
            if (!is_pix) begin
              gcd_b_d = bus.rx_data_i;
              state_d = StGcdArm;
            end else begin
              error_d = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StGcdArm: begin
          if (gcd_rise) begin
            gcd_start_d = 1'b1;
            to_cnt_d    = '0;
            state_d     = StGcdRun;
          end
        end
        StGcdRun: begin
          if (bus.gcd_done_i) begin
            tx_data_d = bus.gcd_result_i;
            tx_load_d = 1'b1;
            done_d    = 1'b1;
            state_d   = StGcdDone;
          end else if (gcd_fall || timeout) begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
        StGcdDone: begin
          if (rx) begin
            done_d  = 1'b0;
            state_d = StIdle;
          end
        end
        StSobFill: begin
          if (rx) begin
            if (is_pix) begin
              push      = 1'b1;
              pix_cnt_d = pix_cnt_q + PixCntW'(1);
              if (pix_cnt_q == PixCntW'(SOBEL_WINDOW - 1)) state_d = StSobArm;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        StSobArm: begin
          if (rx) begin
            if (is_pix) begin
              push   = 1'b1;
              done_d = 1'b0;
            end else begin
              error_d = 1'b1;
            end
          end
          if (sob_rise) begin
            sobel_start_d = 1'b1;
            to_cnt_d      = '0;
            state_d       = StSobRun;
          end
        end
        StSobRun: begin
          if (rx) error_d = 1'b1;
          if (bus.sobel_done_i) begin
            tx_data_d = {1'b1, bus.sobel_result_i};
            tx_load_d = 1'b1;
            done_d    = 1'b1;
            state_d   = StSobArm;
          end else if (timeout) begin
            error_d = 1'b1;
            state_d = StSobArm;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    pix_valid_d = push;
    pix_d       = push ? bus.rx_data_i[PixW-1:0] : pix_q;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= StIdle;
      gcd_en_q      <= 1'b0;
      sobel_en_q    <= 1'b0;
      gcd_a_q       <= '0;
      gcd_b_q       <= '0;
      gcd_start_q   <= 1'b0;
      pix_q         <= '0;
      pix_valid_q   <= 1'b0;
      sobel_start_q <= 1'b0;
      tx_data_q     <= '0;
      tx_load_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      pix_cnt_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      gcd_en_q      <= bus.gcd_en_i;
      sobel_en_q    <= bus.sobel_en_i;
      gcd_a_q       <= gcd_a_d;
      gcd_b_q       <= gcd_b_d;
      gcd_start_q   <= gcd_start_d;
      pix_q         <= pix_d;
      pix_valid_q   <= pix_valid_d;
      sobel_start_q <= sobel_start_d;
      tx_data_q     <= tx_data_d;
      tx_load_q     <= tx_load_d;
      done_q        <= done_d;
      error_q       <= error_d;
      pix_cnt_q     <= pix_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign bus.gcd_a_o             = gcd_a_q;
  assign bus.gcd_b_o             = gcd_b_q;
  assign bus.gcd_start_o         = gcd_start_q;
  assign bus.sobel_pixel_o       = pix_q;
  assign bus.sobel_pixel_valid_o = pix_valid_q;
  assign bus.sobel_start_o       = sobel_start_q;
  assign bus.tx_data_o           = tx_data_q;
  assign bus.tx_load_o           = tx_load_q;
  assign bus.done_o              = done_q;
  assign bus.busy_o              = (state_q == StGcdRun) || (state_q == StSobRun);
  assign bus.error_o             = error_q;

endmodule
